data_mux_stream_sel: RTL

- Parametrised N-to-1 AXI-Stream link multiplexer with a registered output stage and proper valid/ready backpressure.
- Inserts a programmable burst of idle words after each fast-control link reset. The idle word is replaced by the BX0 idle word on an orbit-sync edge.
- The channel select is staged and switches only on an orbit boundary, so no partial frames are emitted.
- Sits between the per-link formatters and the serialiser/transmit path.

---
 rtl/data_mux_stream_sel.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_mux_stream_sel.sv
// data_mux_stream_sel: N-to-1 AXI-Stream link multiplexer with a registered
// output stage. After each fast-control link reset it inserts a programmable
// burst of idle words (BX0 idle word on an orbit-sync edge). The channel
// select is staged and normally switches only on an orbit edge.
// Optional status counters are compiled in with DATA_MUX_STREAM_SEL_STATUS_EN.

module data_mux_stream_sel #(
  parameter int DATA_WIDTH          = 32,
  parameter int N_INPUTS            = 16,
  parameter int SEL_WIDTH           = $clog2(N_INPUTS),
  parameter int OUTPUT_REVERSE_BITS = 1,
  parameter int SEL_IMMEDIATE       = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] tdata_in [N_INPUTS],
  input  logic [N_INPUTS-1:0]   tvalid_in,
  output logic [N_INPUTS-1:0]   tready_in,
  output logic [DATA_WIDTH-1:0] tdata_out,
  output logic                  tvalid_out,
  input  logic                  tready_out,
  input  logic [15:0]           n_idle_words,
  input  logic [SEL_WIDTH-1:0]  output_select,
  input  logic [DATA_WIDTH-1:0] idle_word,
  input  logic [DATA_WIDTH-1:0] idle_word_bx0,
  input  logic                  fc_orbitSync,
  input  logic                  fc_linkReset,
  output logic [SEL_WIDTH-1:0]  active_select,
  output logic                  idle_active
`ifdef DATA_MUX_STREAM_SEL_STATUS_EN
  ,
  input  logic                  clear_stats,
  output logic [31:0]           idle_words_sent,
  output logic [31:0]           gap_beats
`endif
);

  if (N_INPUTS < 2 || N_INPUTS > 256) begin : g_bad_n_inputs
    $error("data_mux_stream_sel: N_INPUTS must be 2..256");
  end

  logic                  adv;
  logic                  orbit_q;
  logic                  lreset_q;
  logic                  orbit_rise;
  logic                  lreset_rise;
  logic [15:0]           idle_count;
  logic                  sel_in_range;
  logic [DATA_WIDTH-1:0] mux_word;
  logic                  mux_valid;
  logic [DATA_WIDTH-1:0] out_word;

  // The output register accepts a new beat whenever it is empty or drained;
  // every input link advances in lockstep with it.
  assign adv         = !tvalid_out || tready_out;
  assign tready_in   = {N_INPUTS{adv}};
  assign orbit_rise  = fc_orbitSync & !orbit_q;
  assign lreset_rise = fc_linkReset & !lreset_q;
  assign idle_active = (idle_count != 16'd0);

  // With a power-of-two channel count every select code is a real channel.
  if (N_INPUTS == (1 << SEL_WIDTH)) begin : g_sel_full
    assign sel_in_range = 1'b1;
  end else begin : g_sel_partial
    assign sel_in_range = (active_select < SEL_WIDTH'(N_INPUTS));
  end

  // Edge history only moves on advancing beats, so an edge seen during a
  // stall stays pending until the beat it belongs to is actually taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of block ordering.
      orbit_q  <= 1'b0;
      lreset_q <= 1'b0;
    end else if (adv) begin
      orbit_q  <= fc_orbitSync;
      lreset_q <= fc_linkReset;
    end
  end

  // Idle countdown: a link-reset edge (re)loads, otherwise count down per beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_count <= 16'd0;
    end else if (lreset_rise) begin
      idle_count <= n_idle_words;
    end else if (idle_active && adv) begin
      idle_count <= idle_count - 16'd1;
    end
  end

  // Stage the requested channel; it applies from the following beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_select <= '0;
    end else if (adv && (SEL_IMMEDIATE != 0 || orbit_rise)) begin
      active_select <= output_select;
    end
  end

  // Pick the next output beat: idle pattern, selected channel, or nothing.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    mux_word  = '0;
    mux_valid = 1'b0;
    if (idle_active) begin
      mux_word  = orbit_rise ? idle_word_bx0 : idle_word;
      mux_valid = 1'b1;
    end else if (sel_in_range) begin
      mux_word  = tdata_in[active_select];
      mux_valid = tvalid_in[active_select];
    end
  end

  if (OUTPUT_REVERSE_BITS != 0) begin : g_reverse
    // Mirror the word so bit i of the output is bit DATA_WIDTH-1-i.
    always_comb begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        out_word[i] = mux_word[DATA_WIDTH-1-i];
      end
    end
  end else begin : g_straight
    assign out_word = mux_word;
  end

  // Output register: load on an advancing beat, hold while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tdata_out  <= '0;
      tvalid_out <= 1'b0;
    end else if (adv) begin
      tdata_out  <= out_word;
      tvalid_out <= mux_valid;
    end
  end

`ifdef DATA_MUX_STREAM_SEL_STATUS_EN
  // Saturating counters of accepted idle beats and of empty channel beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_words_sent <= '0;
      gap_beats       <= '0;
    end else if (clear_stats) begin
      idle_words_sent <= '0;
      gap_beats       <= '0;
    end else if (adv) begin
      if (idle_active && idle_words_sent != 32'hFFFF_FFFF)
        idle_words_sent <= idle_words_sent + 32'd1;
      if (!idle_active && !mux_valid && gap_beats != 32'hFFFF_FFFF)
        gap_beats <= gap_beats + 32'd1;
    end
  end
`endif

endmodule
